// File: rtl/snake_move_ctrl_if.sv
// Segment RAM port bundle between snake_move_ctrl (master) and the body RAM (slave).
interface snake_move_ctrl_if #(
    parameter int unsigned AW      = 4,
    parameter int unsigned COORD_W = 6
);
    logic [AW-1:0]      rd_addr;
    logic [COORD_W-1:0] rd_x;
    logic [COORD_W-1:0] rd_y;
    logic               wr_en;
    logic [AW-1:0]      wr_addr;
    logic [COORD_W-1:0] wr_x;
    logic [COORD_W-1:0] wr_y;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_x, wr_y,
        input  rd_x, rd_y
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_x, wr_y,
        output rd_x, rd_y
    );
endinterface

// File: rtl/snake_move_ctrl.sv
// Snake body sequencer: tick pacing, direction latch and segment-RAM shift/head write.
module snake_move_ctrl #(
    parameter int unsigned TICK_DIV = 2500000,
    parameter int unsigned MAX_LEN  = 16,
    parameter int unsigned COORD_W  = 6,
    parameter int unsigned INIT_X   = 20,
    parameter int unsigned INIT_Y   = 20
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [7:0]                key_code,
    input  logic                      key_valid,
    input  logic                      run,
    input  logic                      init_snake,
    input  logic                      grow,
    snake_move_ctrl_if.master         ram,
    output logic [COORD_W-1:0]        head_x,
    output logic [COORD_W-1:0]        head_y,
    output logic [$clog2(MAX_LEN):0]  length,
    output logic                      busy,
    output logic                      move_done
);

    localparam int unsigned AW = $clog2(MAX_LEN);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned TW = $clog2(TICK_DIV);

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_LEFT  = 2'd3;

    localparam logic [LW-1:0] INIT_LEN = LW'(3);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_HEAD,
        S_DONE,
        S_INIT
    } state_e;

    state_e             state_q, state_d;
    logic [LW-1:0]      step_q, step_d;
    logic [LW-1:0]      len_l_q, len_l_d;
    logic [LW-1:0]      length_q, length_d;
    logic [COORD_W-1:0] head_x_q, head_x_d;
    logic [COORD_W-1:0] head_y_q, head_y_d;
    logic [1:0]         dir_q, dir_d;
    logic [1:0]         pend_dir_q, pend_dir_d;
    logic [TW-1:0]      tick_cnt_q, tick_cnt_d;
    logic               tick_pend_q, tick_pend_d;
    logic               grow_pend_q, grow_pend_d;

    logic [AW-1:0]      rd_addr_q, rd_addr_d;
    logic               wr_en_q, wr_en_d;
    logic [AW-1:0]      wr_addr_q, wr_addr_d;
    logic [COORD_W-1:0] wr_x_q, wr_x_d;
    logic [COORD_W-1:0] wr_y_q, wr_y_d;
    logic               pass_q, pass_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               key_hit;
    logic [1:0]         key_dir;
    logic [COORD_W-1:0] nxt_x, nxt_y;
    logic               tick_wrap;

    // Scan code to direction decode; unknown codes are not hits.
    always_comb begin
        key_hit = 1'b0;
        key_dir = DIR_RIGHT;
        if (key_valid) begin
            case (key_code)
                8'h75: begin key_hit = 1'b1; key_dir = DIR_UP;    end
                8'h74: begin key_hit = 1'b1; key_dir = DIR_RIGHT; end
                8'h72: begin key_hit = 1'b1; key_dir = DIR_DOWN;  end
                8'h6B: begin key_hit = 1'b1; key_dir = DIR_LEFT;  end
                default: ;
            endcase
        end
    end

    // Next head from the committed direction; coordinates wrap around the grid.
    always_comb begin
        nxt_x = head_x_q;
        nxt_y = head_y_q;
        case (dir_q)
            DIR_UP:    nxt_y = head_y_q - COORD_W'(1);
            DIR_RIGHT: nxt_x = head_x_q + COORD_W'(1);
            DIR_DOWN:  nxt_y = head_y_q + COORD_W'(1);
            DIR_LEFT:  nxt_x = head_x_q - COORD_W'(1);
            default: ;
        endcase
    end

    // Next state, bookkeeping and registered RAM/status outputs.
    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        len_l_d     = len_l_q;
        length_d    = length_q;
        head_x_d    = head_x_q;
        head_y_d    = head_y_q;
        dir_d       = dir_q;
        pend_dir_d  = pend_dir_q;
        tick_cnt_d  = tick_cnt_q;
        tick_pend_d = tick_pend_q;
        grow_pend_d = grow_pend_q | grow;
        tick_wrap   = 1'b0;

        rd_addr_d   = '0;
        wr_en_d     = 1'b0;
        wr_addr_d   = '0;
        wr_x_d      = '0;
        wr_y_d      = '0;
        pass_d      = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;

        // Move tick divider, frozen while the game is not running.
        if (run) begin
            if (tick_cnt_q == TW'(TICK_DIV - 1)) begin
                tick_cnt_d = '0;
                tick_wrap  = 1'b1;
            end else begin
                tick_cnt_d = tick_cnt_q + TW'(1);
            end
        end

        // Reversal check is against the committed direction, not the pending one.
        if (key_hit && (key_dir != (dir_q ^ DIR_DOWN))) begin
            pend_dir_d = key_dir;
        end

        case (state_q)
            S_IDLE: begin
                if (tick_pend_q && run) begin
                    state_d     = S_SHIFT;
                    step_d      = '0;
                    dir_d       = pend_dir_q;
                    tick_pend_d = 1'b0;
                    grow_pend_d = grow;
                    if (grow_pend_q && (length_q < LW'(MAX_LEN))) begin
                        len_l_d = length_q + LW'(1);
                    end else begin
                        len_l_d = length_q;
                    end
                end
            end
            S_SHIFT: begin
                if (step_q == len_l_q - LW'(1)) begin
                    state_d = S_HEAD;
                    step_d  = '0;
                end else begin
                    step_d  = step_q + LW'(1);
                end
            end
            S_HEAD: begin
                state_d  = S_DONE;
                head_x_d = nxt_x;
                head_y_d = nxt_y;
                length_d = len_l_q;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_INIT: begin
                if (step_q == LW'(2)) begin
                    state_d = S_IDLE;
                    step_d  = '0;
                end else begin
                    step_d  = step_q + LW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                step_d  = '0;
            end
        endcase

        // A tick that lands during a move stays pending for the next one.
        if (tick_wrap) begin
            tick_pend_d = 1'b1;
        end

        // Restart overrides everything else, including a move in flight.
        if (init_snake) begin
            state_d     = S_INIT;
            step_d      = '0;
            len_l_d     = INIT_LEN;
            length_d    = INIT_LEN;
            head_x_d    = COORD_W'(INIT_X);
            head_y_d    = COORD_W'(INIT_Y);
            dir_d       = DIR_RIGHT;
            pend_dir_d  = DIR_RIGHT;
            tick_cnt_d  = '0;
            tick_pend_d = 1'b0;
            grow_pend_d = 1'b0;
        end

        // Outputs are decoded from the state being entered so they line up with it.
        case (state_d)
            S_SHIFT: begin
                busy_d = 1'b1;
                if (step_d <= len_l_d - LW'(2)) begin
                    rd_addr_d = AW'(len_l_d - LW'(2) - step_d);
                end
                if (step_d != '0) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = AW'(len_l_d - step_d);
                    pass_d    = 1'b1;
                end
            end
            S_HEAD: begin
                busy_d  = 1'b1;
                wr_en_d = 1'b1;
                wr_x_d  = nxt_x;
                wr_y_d  = nxt_y;
            end
            S_DONE: begin
                done_d = 1'b1;
            end
            S_INIT: begin
                busy_d    = 1'b1;
                wr_en_d   = 1'b1;
                wr_addr_d = AW'(step_d);
                wr_x_d    = COORD_W'(INIT_X) - COORD_W'(step_d);
                wr_y_d    = COORD_W'(INIT_Y);
            end
            default: ;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            step_q      <= '0;
            len_l_q     <= INIT_LEN;
            length_q    <= INIT_LEN;
            head_x_q    <= COORD_W'(INIT_X);
            head_y_q    <= COORD_W'(INIT_Y);
            dir_q       <= DIR_RIGHT;
            pend_dir_q  <= DIR_RIGHT;
            tick_cnt_q  <= '0;
            tick_pend_q <= 1'b0;
            grow_pend_q <= 1'b0;
            rd_addr_q   <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_x_q      <= '0;
            wr_y_q      <= '0;
            pass_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            len_l_q     <= len_l_d;
            length_q    <= length_d;
            head_x_q    <= head_x_d;
            head_y_q    <= head_y_d;
            dir_q       <= dir_d;
            pend_dir_q  <= pend_dir_d;
            tick_cnt_q  <= tick_cnt_d;
            tick_pend_q <= tick_pend_d;
            grow_pend_q <= grow_pend_d;
            rd_addr_q   <= rd_addr_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_x_q      <= wr_x_d;
            wr_y_q      <= wr_y_d;
            pass_q      <= pass_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // During the shift the RAM read data arriving this cycle is written straight back one slot down.
    assign ram.rd_addr = rd_addr_q;
    assign ram.wr_en   = wr_en_q;
    assign ram.wr_addr = wr_addr_q;
    assign ram.wr_x    = pass_q ? ram.rd_x : wr_x_q;
    assign ram.wr_y    = pass_q ? ram.rd_y : wr_y_q;

    assign head_x    = head_x_q;
    assign head_y    = head_y_q;
    assign length    = length_q;
    assign busy      = busy_q;
    assign move_done = done_q;

endmodule

// File: tb/tb_snake_move_ctrl.sv
// Scoreboard bench for snake_move_ctrl: directed moves, expected RAM writes and head/length per move.
module tb_snake_move_ctrl;

    localparam int unsigned TICK_DIV = 20;
    localparam int unsigned MAX_LEN  = 8;
    localparam int unsigned COORD_W  = 4;
    localparam int unsigned INIT_X   = 8;
    localparam int unsigned INIT_Y   = 8;
    localparam int unsigned AW       = 3;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [7:0]         key_code;
    logic               key_valid;
    logic               run;
    logic               init_snake;
    logic               grow;
    logic [COORD_W-1:0] head_x;
    logic [COORD_W-1:0] head_y;
    logic [AW:0]        length;
    logic               busy;
    logic               move_done;

    snake_move_ctrl_if #(.AW(AW), .COORD_W(COORD_W)) ram_if ();

    snake_move_ctrl #(
        .TICK_DIV (TICK_DIV),
        .MAX_LEN  (MAX_LEN),
        .COORD_W  (COORD_W),
        .INIT_X   (INIT_X),
        .INIT_Y   (INIT_Y)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_code   (key_code),
        .key_valid  (key_valid),
        .run        (run),
        .init_snake (init_snake),
        .grow       (grow),
        .ram        (ram_if),
        .head_x     (head_x),
        .head_y     (head_y),
        .length     (length),
        .busy       (busy),
        .move_done  (move_done)
    );

    always #5 clk = ~clk;

    // Segment RAM with one-cycle read latency.
    logic [COORD_W-1:0] mem_x [MAX_LEN];
    logic [COORD_W-1:0] mem_y [MAX_LEN];

    always @(posedge clk) begin
        ram_if.rd_x <= mem_x[ram_if.rd_addr];
        ram_if.rd_y <= mem_y[ram_if.rd_addr];
        if (ram_if.wr_en) begin
            mem_x[ram_if.wr_addr] <= ram_if.wr_x;
            mem_y[ram_if.wr_addr] <= ram_if.wr_y;
        end
    end

    typedef struct {
        int addr;
        int x;
        int y;
    } wr_t;

    typedef struct {
        int x;
        int y;
        int len;
    } done_t;

    wr_t   exp_wr[$];
    done_t exp_done[$];
    wr_t   mon_w;
    done_t mon_d;

    int tests = 0;
    int fails = 0;

    // Expected snake body, index 0 is the head.
    int sx[MAX_LEN];
    int sy[MAX_LEN];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push_wr(input int a, input int x, input int y);
        wr_t w;
        w.addr = a;
        w.x    = x;
        w.y    = y;
        exp_wr.push_back(w);
    endtask

    task automatic push_init();
        for (int k = 0; k < 3; k++) begin
            push_wr(k, INIT_X - k, INIT_Y);
            sx[k] = INIT_X - k;
            sy[k] = INIT_Y;
        end
    endtask

    // Queue one move: shift writes from tail to slot 1, then the hand-given head at slot 0.
    task automatic move(input int hx, input int hy, input int len);
        done_t d;
        for (int a = len - 1; a >= 1; a--) begin
            push_wr(a, sx[a-1], sy[a-1]);
        end
        push_wr(0, hx, hy);
        d.x   = hx;
        d.y   = hy;
        d.len = len;
        exp_done.push_back(d);
        for (int a = len - 1; a >= 1; a--) begin
            sx[a] = sx[a-1];
            sy[a] = sy[a-1];
        end
        sx[0] = hx;
        sy[0] = hy;
    endtask

    task automatic wait_done();
        bit got = 1'b0;
        for (int i = 0; i < 80 && !got; i++) begin
            @(negedge clk);
            if (move_done) got = 1'b1;
        end
        check("move_done_seen", int'(got), 1);
    endtask

    task automatic pulse_key(input logic [7:0] code);
        @(posedge clk);
        #1;
        key_code  = code;
        key_valid = 1'b1;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        key_code  = 8'h00;
    endtask

    task automatic pulse_grow();
        @(posedge clk);
        #1;
        grow = 1'b1;
        @(posedge clk);
        #1;
        grow = 1'b0;
    endtask

    // Monitor: every RAM write and every move_done is checked against the queues.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (ram_if.wr_en) begin
                if (exp_wr.size() == 0) begin
                    check("unexpected_wr_addr", int'(ram_if.wr_addr), -1);
                end else begin
                    mon_w = exp_wr.pop_front();
                    check("wr_addr", int'(ram_if.wr_addr), mon_w.addr);
                    check("wr_x", int'(ram_if.wr_x), mon_w.x);
                    check("wr_y", int'(ram_if.wr_y), mon_w.y);
                end
            end
            if (move_done) begin
                if (exp_done.size() == 0) begin
                    check("unexpected_move_done", 1, 0);
                end else begin
                    mon_d = exp_done.pop_front();
                    check("done_head_x", int'(head_x), mon_d.x);
                    check("done_head_y", int'(head_y), mon_d.y);
                    check("done_length", int'(length), mon_d.len);
                    check("done_busy_low", int'(busy), 0);
                end
            end
        end
    end

    initial begin
        int  cnt;
        bit  got;

        rst_n      = 1'b0;
        key_code   = 8'h00;
        key_valid  = 1'b0;
        run        = 1'b0;
        init_snake = 1'b0;
        grow       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_head_x", int'(head_x), 8);
        check("rst_head_y", int'(head_y), 8);
        check("rst_length", int'(length), 3);
        check("rst_busy", int'(busy), 0);
        check("rst_move_done", int'(move_done), 0);
        check("rst_wr_en", int'(ram_if.wr_en), 0);
        check("rst_rd_addr", int'(ram_if.rd_addr), 0);
        check("rst_wr_addr", int'(ram_if.wr_addr), 0);

        // Init: (8,8),(7,8),(6,8) into slots 0..2 with busy high for three cycles
        push_init();
        @(posedge clk);
        #1;
        init_snake = 1'b1;
        @(posedge clk);
        #1;
        init_snake = 1'b0;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (busy) cnt++;
        end
        check("init_busy_cycles", cnt, 3);
        check("init_length", int'(length), 3);

        // First move: move_done 24 edges after the first edge that samples run high
        move(9, 8, 3);
        @(posedge clk);
        #1;
        run = 1'b1;
        @(posedge clk);
        cnt = 0;
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
            if (move_done) got = 1'b1;
        end
        check("first_move_latency", cnt, 24);

        // Reversal LEFT while moving RIGHT is dropped
        pulse_key(8'h6B);
        move(10, 8, 3);
        wait_done();

        // UP then LEFT within one tick: LEFT still a reversal of committed RIGHT
        pulse_key(8'h75);
        pulse_key(8'h6B);
        move(10, 7, 3);
        wait_done();

        // LEFT now legal against committed UP
        pulse_key(8'h6B);
        move(9, 7, 3);
        wait_done();

        // Grow on each move until capped at 8
        for (int k = 0; k < 6; k++) begin
            pulse_grow();
            move(8 - k, 7, (k < 4) ? (4 + k) : 8);
            wait_done();
        end
        check("len_capped", int'(length), 8);

        // Move UP down to y=0, then wrap to y=15
        pulse_key(8'h75);
        for (int k = 0; k < 7; k++) begin
            move(3, 6 - k, 8);
            wait_done();
        end
        move(3, 15, 8);
        wait_done();
        check("wrap_head_y", int'(head_y), 15);

        // Move RIGHT up to x=15, then wrap to x=0
        pulse_key(8'h74);
        for (int k = 0; k < 12; k++) begin
            move(4 + k, 15, 8);
            wait_done();
        end
        move(0, 15, 8);
        wait_done();
        check("wrap_head_x", int'(head_x), 0);

        // Abort in SHIFT cycle 1: only the cycle-1 shift write, then the init writes
        push_wr(7, sx[6], sy[6]);
        push_init();
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (busy) got = 1'b1;
        end
        check("abort_busy_seen", int'(got), 1);
        grow = 1'b1;
        @(posedge clk);
        #1;
        grow       = 1'b0;
        init_snake = 1'b1;
        @(posedge clk);
        #1;
        init_snake = 1'b0;
        repeat (5) @(negedge clk);
        check("abort_head_x", int'(head_x), 8);
        check("abort_head_y", int'(head_y), 8);
        check("abort_length", int'(length), 3);

        // Grow requested before the abort must be gone: next move stays at length 3
        move(9, 8, 3);
        wait_done();

        repeat (4) @(negedge clk);
        check("wr_queue_empty", exp_wr.size(), 0);
        check("done_queue_empty", exp_done.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
